// File: rtl/regfile_wb_arbiter_if.sv
// Write-port arbiter bus: pipeline writeback (A), long-latency results (B),
// decode hazard lookups and the register file write port.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    logic                     a_valid;
    logic [4:0]               a_rd;
    logic [31:0]              a_data;
    logic                     b_valid;
    logic                     b_ready;
    logic [4:0]               b_rd;
    logic [31:0]              b_data;
    logic [4:0]               rs1_addr;
    logic [4:0]               rs2_addr;
    logic                     hazard_rs1;
    logic                     hazard_rs2;
    logic                     stall_req;
    logic                     wr_en;
    logic [4:0]               wr_addr;
    logic [31:0]              wr_data;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, rs1_addr, rs2_addr,
        input  b_ready, hazard_rs1, hazard_rs2, stall_req, wr_en, wr_addr, wr_data, fifo_count
    );
    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, rs1_addr, rs2_addr,
        output b_ready, hazard_rs1, hazard_rs2, stall_req, wr_en, wr_addr, wr_data, fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between pipeline writeback (A, always wins)
// and a FIFO of long-latency results (B), with kill, hazard and starvation tracking.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic [SW-1:0] starve_q;
    logic          stall_q;
    logic          rdy_en_q;

    logic a_claim, head_live, drain_live, pop, push, enq_live;

    // Reset gates port A directly so the write port is quiet while reset is held.
    assign a_claim    = reset_n && bus.a_valid && (bus.a_rd != 5'd0);
    assign head_live  = (count_q != '0) && live_q[rptr_q];
    assign drain_live = !a_claim && head_live;
    assign pop        = (count_q != '0) && (!live_q[rptr_q] || drain_live);
    assign push       = bus.b_valid && bus.b_ready && (bus.b_rd != 5'd0);
    assign enq_live   = !(a_claim && (bus.a_rd == bus.b_rd));

    assign bus.b_ready    = rdy_en_q && (count_q != CW'(DEPTH));
    assign bus.fifo_count = count_q;
    assign bus.stall_req  = stall_q;

    always_comb begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = 5'd0;
        bus.wr_data = 32'd0;
        if (a_claim) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = bus.a_rd;
            bus.wr_data = bus.a_data;
        end else if (drain_live) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = rd_q[rptr_q];
            bus.wr_data = data_q[rptr_q];
        end
    end

    // Popped slots have live cleared, so live alone marks an occupied, un-killed entry.
    always_comb begin
        bus.hazard_rs1 = 1'b0;
        bus.hazard_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && rd_q[i] == bus.rs1_addr && bus.rs1_addr != 5'd0) bus.hazard_rs1 = 1'b1;
            if (live_q[i] && rd_q[i] == bus.rs2_addr && bus.rs2_addr != 5'd0) bus.hazard_rs2 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= 32'd0;
            end
            live_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            // Port A is program-newer than anything queued: kill matching entries.
            for (int i = 0; i < DEPTH; i++)
                if (a_claim && rd_q[i] == bus.a_rd) live_q[i] <= 1'b0;
            if (pop) begin
                live_q[rptr_q] <= 1'b0;
                rptr_q         <= rptr_q + 1'b1;
            end
            if (push) begin
                rd_q[wptr_q]   <= bus.b_rd;
                data_q[wptr_q] <= bus.b_data;
                live_q[wptr_q] <= enq_live;
                wptr_q         <= wptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);

            if (head_live && !drain_live) begin
                if (starve_q != SW'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
                if (starve_q == SW'(STARVE_LIMIT - 1)) stall_q <= 1'b1;
            end else begin
                starve_q <= '0;
            end
            if (drain_live) stall_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: drives at posedge+1, checks settled outputs.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_wr = 0;
    int   wr_snap;
    logic [31:0] rf [32];

    regfile_wb_arbiter_if #(.DEPTH(4)) bus ();
    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Register file model: captures whatever the write port presents at each edge.
    always @(posedge clk) begin
        if (bus.wr_en) begin
            rf[bus.wr_addr] = bus.wr_data;
            n_wr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        idle();
        bus.rs1_addr = 0; bus.rs2_addr = 0;
        // Reset state, with port A asserted to prove it is masked.
        bus.a_valid = 1; bus.a_rd = 5'd3; bus.a_data = 32'hDEAD;
        #1;
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_bready", bus.b_ready, 0);
        chk("rst_stall", bus.stall_req, 0);
        chk("rst_wren", bus.wr_en, 0);
        chk("rst_wraddr", bus.wr_addr, 0);
        chk("rst_wrdata", bus.wr_data, 0);
        idle();
        tick(); tick();
        reset_n = 1;
        #1;
        chk("rel_bready_low", bus.b_ready, 0);
        tick();
        chk("rel_bready_high", bus.b_ready, 1);

        // Port B alone: no bypass, drains the cycle after enqueue.
        bus.b_valid = 1; bus.b_rd = 5; bus.b_data = 32'h1234;
        #1;
        chk("b_nobypass", bus.wr_en, 0);
        tick();
        idle(); #1;
        chk("b_count1", bus.fifo_count, 1);
        chk("b_wren", bus.wr_en, 1);
        chk("b_wraddr", bus.wr_addr, 5);
        chk("b_wrdata", bus.wr_data, 32'h1234);
        tick();
        chk("b_count0", bus.fifo_count, 0);
        chk("b_rf5", rf[5], 32'h1234);

        // Fill with port A busy on x10, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            bus.b_valid = 1; bus.b_rd = 5'(i); bus.b_data = 32'h10 * i;
            bus.a_valid = 1; bus.a_rd = 10; bus.a_data = 32'(i);
            #1;
            chk("fill_wraddr", bus.wr_addr, 10);
            tick();
        end
        bus.b_valid = 0; #1;
        chk("full_count", bus.fifo_count, 4);
        chk("full_bready", bus.b_ready, 0);
        chk("full_awins", bus.wr_addr, 10);
        tick();
        bus.a_valid = 0; #1;
        chk("drain1_addr", bus.wr_addr, 1);
        chk("drain1_data", bus.wr_data, 32'h10);
        chk("drain1_bready", bus.b_ready, 0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("drain_bready", bus.b_ready, 1);
            chk("drain_addr", bus.wr_addr, 5'(i));
            chk("drain_data", bus.wr_data, 32'h10 * i);
        end
        tick();
        chk("drain_empty", bus.fifo_count, 0);
        chk("rf10", rf[10], 4);
        chk("rf3", rf[3], 32'h30);

        // Kill: queued x7 superseded by a port A write.
        bus.rs1_addr = 7;
        bus.b_valid = 1; bus.b_rd = 7; bus.b_data = 32'hAA;
        bus.a_valid = 1; bus.a_rd = 10; bus.a_data = 32'h5;
        tick();
        bus.b_valid = 0; bus.a_rd = 7; bus.a_data = 32'hBB; #1;
        chk("kill_haz_before", bus.hazard_rs1, 1);
        chk("kill_awrite", bus.wr_data, 32'hBB);
        tick();
        idle(); #1;
        chk("kill_haz_after", bus.hazard_rs1, 0);
        chk("kill_nowrite", bus.wr_en, 0);
        chk("kill_count", bus.fifo_count, 1);
        tick();
        chk("kill_popped", bus.fifo_count, 0);
        chk("kill_rf7", rf[7], 32'hBB);

        // Same-edge kill: entry enqueued with live=0.
        bus.rs1_addr = 8;
        bus.b_valid = 1; bus.b_rd = 8; bus.b_data = 32'h11;
        bus.a_valid = 1; bus.a_rd = 8; bus.a_data = 32'h22;
        tick();
        idle(); #1;
        chk("same_haz", bus.hazard_rs1, 0);
        chk("same_nowrite", bus.wr_en, 0);
        chk("same_count", bus.fifo_count, 1);
        tick();
        chk("same_rf8", rf[8], 32'h22);

        // x0 handshake enqueues nothing; hazard on x9 but never on x0.
        bus.b_valid = 1; bus.b_rd = 0; bus.b_data = 32'h99;
        tick();
        chk("x0_count", bus.fifo_count, 0);
        bus.rs1_addr = 0; bus.rs2_addr = 9;
        bus.b_rd = 9; #1;
        chk("haz_not_enq", bus.hazard_rs2, 0);
        tick();
        idle(); #1;
        chk("haz_rs2", bus.hazard_rs2, 1);
        chk("haz_rs1_x0", bus.hazard_rs1, 0);
        tick();
        chk("haz_rs2_drop", bus.hazard_rs2, 0);

        // Starvation: port A hogs the write port while one live entry waits.
        bus.b_valid = 1; bus.b_rd = 12; bus.b_data = 32'hCC;
        bus.a_valid = 1; bus.a_rd = 11; bus.a_data = 32'h77;
        tick();
        bus.b_valid = 0;
        for (int k = 1; k <= 7; k++) tick();
        chk("starve_7", bus.stall_req, 0);
        tick();
        chk("starve_8", bus.stall_req, 1);
        chk("starve_awins", bus.wr_addr, 11);
        bus.a_valid = 0; #1;
        chk("starve_drain_addr", bus.wr_addr, 12);
        chk("starve_hold", bus.stall_req, 1);
        tick();
        chk("starve_clear", bus.stall_req, 0);
        chk("starve_rf12", rf[12], 32'hCC);

        // Async reset with three entries pending.
        bus.rs1_addr = 1;
        for (int i = 1; i <= 3; i++) begin
            bus.b_valid = 1; bus.b_rd = 5'(i); bus.b_data = 32'hF0 + i;
            bus.a_valid = 1; bus.a_rd = 13; bus.a_data = 32'h3;
            tick();
        end
        bus.b_valid = 0;
        chk("pre_rst_count", bus.fifo_count, 3);
        chk("pre_rst_haz", bus.hazard_rs1, 1);
        #2 reset_n = 0; #1;
        chk("arst_count", bus.fifo_count, 0);
        chk("arst_bready", bus.b_ready, 0);
        chk("arst_haz", bus.hazard_rs1, 0);
        chk("arst_wren", bus.wr_en, 0);
        chk("arst_stall", bus.stall_req, 0);
        idle();
        wr_snap = n_wr;
        tick(); tick();
        reset_n = 1;
        for (int k = 0; k < 4; k++) tick();
        chk("arst_nowrites", n_wr, wr_snap);
        chk("arst_empty", bus.fifo_count, 0);
        chk("arst_bready_back", bus.b_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
